// File: rtl/ram_bist_master_if.sv
// rtl/ram_bist_master_if.sv - single-port RAM access bus between the BIST master and the RAM
interface ram_bist_master_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  en;
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  out_en;

    modport master (
        output en, wr_rd, addr, data_in,
        input  data_out, out_en
    );

    modport slave (
        input  en, wr_rd, addr, data_in,
        output data_out, out_en
    );
endinterface

// File: rtl/ram_bist_master.sv
// rtl/ram_bist_master.sv - write/read-back RAM self-test master; optional RAM_BIST_INVERT_PASS_EN adds an inverted-pattern pass
module ram_bist_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int TIMEOUT    = 15,
    parameter int ERR_W      = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic                  timeout,
`ifdef RAM_BIST_INVERT_PASS_EN
    output logic                  pass_phase,
`endif
    ram_bist_master_if.master     ram
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, RD_GAP, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  phase;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  mismatch;

    function automatic logic [DATA_WIDTH-1:0] pat(input logic [DATA_WIDTH-1:0] s,
                                                  input logic [ADDR_WIDTH-1:0] a,
                                                  input logic inv);
        logic [DATA_WIDTH-1:0] p;
        p = s + DATA_WIDTH'(a);
        return inv ? ~p : p;
    endfunction

    assign addr_nxt = ram.addr + 1'b1;
    assign mismatch = (ram.data_out != pat(seed_q, ram.addr, phase));

`ifdef RAM_BIST_INVERT_PASS_EN
    assign pass_phase = phase;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state           <= IDLE;
            ram.en          <= 1'b0;
            ram.wr_rd       <= 1'b0;
            ram.addr        <= '0;
            ram.data_in     <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            timeout         <= 1'b0;
            seed_q          <= '0;
            wait_cnt        <= '0;
            phase           <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    ram.en <= 1'b0;
                    if (start) begin
                        seed_q          <= seed;
                        err_count       <= '0;
                        first_fail_addr <= '0;
                        timeout         <= 1'b0;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        busy            <= 1'b1;
                        phase           <= 1'b0;
                        ram.en          <= 1'b1;
                        ram.wr_rd       <= 1'b1;
                        ram.addr        <= '0;
                        ram.data_in     <= seed;
                        state           <= WRITE;
                    end
                end
                WRITE: begin
                    if (ram.addr == LAST_ADDR) begin
                        ram.addr  <= '0;
                        ram.wr_rd <= 1'b0;
                        state     <= RD_REQ;
                    end else begin
                        ram.addr    <= addr_nxt;
                        ram.data_in <= pat(seed_q, addr_nxt, phase);
                    end
                end
                RD_REQ: begin
                    wait_cnt <= '0;
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (ram.out_en) begin
                        if (mismatch) begin
                            if (err_count == '0)
                                first_fail_addr <= ram.addr;
                            if (err_count != {ERR_W{1'b1}})
                                err_count <= err_count + 1'b1;
                        end
                        ram.en <= 1'b0;
                        state  <= RD_GAP;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        // Abort the whole run: a dead RAM port makes later reads meaningless.
                        timeout <= 1'b1;
                        ram.en  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RD_GAP: begin
                    if (ram.addr != LAST_ADDR) begin
                        ram.addr <= addr_nxt;
                        ram.en   <= 1'b1;
                        state    <= RD_REQ;
                    end
`ifdef RAM_BIST_INVERT_PASS_EN
                    else if (!phase) begin
                        phase       <= 1'b1;
                        ram.addr    <= '0;
                        ram.en      <= 1'b1;
                        ram.wr_rd   <= 1'b1;
                        ram.data_in <= ~seed_q;
                        state       <= WRITE;
                    end
`endif
                    else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !timeout;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_bist_master.sv
// tb/tb_ram_bist_master.sv - randomized scoreboard bench for ram_bist_master with a behavioural RAM
module tb_ram_bist_master;
    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] seed;
    logic       busy, done, pass, timeout;
    logic [7:0] err_count;
    logic [3:0] first_fail_addr;
`ifdef RAM_BIST_INVERT_PASS_EN
    logic       pass_phase;
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    ram_bist_master_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ram ();

    ram_bist_master dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .seed            (seed),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_fail_addr (first_fail_addr),
        .timeout         (timeout),
`ifdef RAM_BIST_INVERT_PASS_EN
        .pass_phase      (pass_phase),
`endif
        .ram             (ram)
    );

    always #5 clk = ~clk;

    // RAM model: random 1..3 cycle read latency, optional stuck-at-0 bits, optional dead out_en
    logic [7:0] mem [16];
    logic [7:0] stuck_mask;
    bit         no_oe;
    int         pend;
    logic [3:0] rd_addr;

    always @(posedge clk) begin
        if (!rstn) begin
            pend         <= 0;
            ram.out_en   <= 1'b0;
            ram.data_out <= 8'h00;
        end else begin
            ram.out_en <= 1'b0;
            if (ram.en && ram.wr_rd)
                mem[ram.addr] <= ram.data_in;
            if (pend == 1) begin
                ram.out_en   <= 1'b1;
                ram.data_out <= mem[rd_addr] & ~stuck_mask;
                pend         <= 0;
            end else if (pend > 1) begin
                pend <= pend - 1;
            end else if (ram.en && !ram.wr_rd && !ram.out_en && !no_oe) begin
                rd_addr <= ram.addr;
                pend    <= int'($urandom_range(1, 3));
            end
        end
    end

    typedef struct { logic [3:0] a; logic [7:0] d; logic ph; } wr_t;
    typedef struct { logic p; logic [7:0] ec; logic [3:0] ffa; logic to; } res_t;

    wr_t  wr_q[$];
    res_t res_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the self-test must write and report, from the pattern rule alone
    task automatic push_expect(input logic [7:0] s, input logic [7:0] m, input bit noe);
        int         errs = 0;
        int         ffa = 0;
        bit         to = 0;
        logic [7:0] p;
        res_t       r;
        for (int ph = 0; ph < PASSES && !to; ph++) begin
            for (int a = 0; a < 16; a++) begin
                p = s + 8'(a);
                if (ph == 1) p = ~p;
                wr_q.push_back('{a: 4'(a), d: p, ph: ph[0]});
            end
            if (noe) begin
                to = 1;
            end else begin
                for (int a = 0; a < 16; a++) begin
                    p = s + 8'(a);
                    if (ph == 1) p = ~p;
                    if ((p & m) != 0) begin
                        if (errs == 0) ffa = a;
                        errs++;
                    end
                end
            end
        end
        r.p   = (errs == 0) && !to;
        r.ec  = (errs > 255) ? 8'hFF : 8'(errs);
        r.ffa = 4'(ffa);
        r.to  = to;
        res_q.push_back(r);
    endtask

    task automatic monitor();
        logic done_prev = 1'b0;
        wr_t  w;
        res_t r;
        forever begin
            @(negedge clk);
            if (rstn && ram.en && ram.wr_rd) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", ram.addr, w.a);
                    chk("wr_data", ram.data_in, w.d);
`ifdef RAM_BIST_INVERT_PASS_EN
                    chk("pass_phase", pass_phase, w.ph);
`endif
                end
            end
            if (rstn && done && !done_prev) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    chk("pass", pass, r.p);
                    chk("err_count", err_count, r.ec);
                    chk("first_fail_addr", first_fail_addr, r.ffa);
                    chk("timeout", timeout, r.to);
                    chk("busy_in_done", busy, 0);
                end
            end
            done_prev = done;
        end
    endtask

    task automatic pulse_start(input logic [7:0] s);
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
        seed  = $urandom();
    endtask

    task automatic wait_done(output int rd_cycles);
        int n = 0;
        rd_cycles = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            if (ram.en && !ram.wr_rd) rd_cycles++;
            n++;
        end
        if (!done) chk("done_within_budget", 0, 1);
    endtask

    task automatic run(input logic [7:0] s, input logic [7:0] m, input bit noe, output int rd_cycles);
        stuck_mask = m;
        no_oe      = noe;
        push_expect(s, m, noe);
        pulse_start(s);
        wait_done(rd_cycles);
        repeat (2) @(negedge clk);
        chk("writes_drained", wr_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"}, ram.en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_status"}, {pass, err_count, first_fail_addr, timeout}, 0);
    endtask

    initial begin
        int rd;
        int n;
        int acc;
        rstn       = 1'b0;
        start      = 1'b0;
        seed       = 8'h00;
        stuck_mask = 8'h00;
        no_oe      = 1'b0;
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
`ifdef RAM_BIST_INVERT_PASS_EN
        chk("reset_pass_phase", pass_phase, 0);
`endif
        rstn = 1'b1;

        run(8'hA5, 8'h00, 1'b0, rd);
        run(8'h00, 8'h08, 1'b0, rd);

        run(8'h3C, 8'h00, 1'b1, rd);
        chk("timeout_read_cycles", rd, 16);
        acc = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram.en) acc++;
        end
        chk("no_access_after_timeout", acc, 0);
        chk("done_held", done, 1);

        // Reset while waiting on the read of address 5
        stuck_mask = 8'h00;
        no_oe      = 1'b0;
        push_expect(8'h51, 8'h00, 1'b0);
        void'(res_q.pop_back());
        pulse_start(8'h51);
        n = 0;
        while (!(ram.en && !ram.wr_rd && ram.addr == 4'd5) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_read_addr5", ram.addr, 5);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_reset");
        rstn = 1'b1;
        wr_q.delete();
        run(8'h77, 8'h00, 1'b0, rd);

        // start while busy is ignored; start in DONE launches a new run
        push_expect(8'h1E, 8'h00, 1'b0);
        pulse_start(8'h1E);
        repeat (4) @(negedge clk);
        pulse_start(8'hC3);
        wait_done(rd);
        repeat (2) @(negedge clk);
        push_expect(8'h62, 8'h00, 1'b0);
        pulse_start(8'h62);
        chk("restart_done_cleared", done, 0);
        chk("restart_busy", busy, 1);
        wait_done(rd);
        repeat (2) @(negedge clk);

        run(8'h0F, 8'h00, 1'b0, rd);

        for (int i = 0; i < 8; i++) begin
            logic [7:0] m;
            m = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            run(8'($urandom()), m, ($urandom_range(0, 7) == 0), rd);
        end

        chk("results_drained", res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
